// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg
//   Shared constants and types for the FIFO write-port arbiter.
//   - DW           : default data width of one FIFO word
//   - FIFO_DEPTH   : capacity of the attached FIFO in words
//   - NREQ_DEFAULT : default number of producer agents
//   - credit_w()   : width of a free-slot counter able to hold 0..depth
//   - req_data_t   : packed request data bus for the default configuration
package fifo_wr_arbiter_pkg;

  localparam int DW           = 32;
  localparam int FIFO_DEPTH   = 16;
  localparam int NREQ_DEFAULT = 4;

  // One extra bit so the counter can represent the full value 'depth'.
  function automatic int credit_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [NREQ_DEFAULT*DW-1:0] req_data_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// fifo_wr_arbiter_rr_pick
//   Combinational rotate-priority encoder. Scans last+1, last+2, ...
//   cyclically and reports the first set bit of the eligible vector.
//   Ports:
//     eligible_i : per-requester eligibility
//     last_i     : index granted most recently (lowest priority now)
//     valid_o    : at least one requester is eligible
//     grant_o    : index of the selected requester (0 when !valid_o)
module fifo_wr_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] eligible_i,
  input  logic [IW-1:0]   last_i,
  output logic            valid_o,
  output logic [IW-1:0]   grant_o
);

  int idx;

  always_comb begin
    valid_o = 1'b0;
    grant_o = '0;
    idx     = 0;
    // k runs to NREQ so that 'last' itself is considered last of all.
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_i) + k) % NREQ;
      if (!valid_o && eligible_i[idx]) begin
        valid_o = 1'b1;
        grant_o = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares one FIFO write port between NREQ producers with round-robin
//   arbitration. A local free-slot credit count replaces the FIFO's
//   lagging full flag: a grant spends a credit, a reported pop returns one.
//   The attached FIFO must be reset together with this block; its reset
//   is active-low and is driven from the inverse of 'reset' at the level
//   above.
//
//   Handshake: a producer raises req[i] with req_data[i*DW +: DW] and holds
//   both until ack[i]. req sampled at edge k gives ack[i]=fifo_wr=1 during
//   cycle k+1. The producer may drop req or change data in the cycle after
//   ack. A requester whose ack is high is masked for that edge, so one
//   requester gets at most one write every two cycles.
//
//   Ports:
//     clk, reset   : clock, synchronous active-high reset
//     req          : per-requester write request
//     req_data     : packed request data, requester i at [i*DW +: DW]
//     ack          : one-cycle pulse, word of that requester written now
//     fifo_data_in : FIFO data input (holds value when idle)
//     fifo_wr      : FIFO write strobe
//     fifo_pop     : consumer pop accepted this cycle
//     credits      : free FIFO slots as tracked here (0..DEPTH)
//     err_pop      : sticky, a pop arrived while credits == DEPTH
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ  = NREQ_DEFAULT,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int DW    = fifo_wr_arbiter_pkg::DW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          ack,
  output logic [DW-1:0]            fifo_data_in,
  output logic                     fifo_wr,
  input  logic                     fifo_pop,
  output logic [$clog2(DEPTH):0]   credits,
  output logic                     err_pop
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = credit_w(DEPTH);
  localparam logic [CW-1:0] CRED_FULL = CW'(DEPTH);

  logic [NREQ-1:0] ack_q, ack_d;
  logic            wr_q, wr_d;
  logic [DW-1:0]   data_q, data_d;
  logic [IW-1:0]   last_q, last_d;
  logic [CW-1:0]   credits_q, credits_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] eligible;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic            issue;

  // Masking the requester being acked stops a second grant while its
  // req is still visibly high in the ack cycle.
  assign eligible = req & ~ack_q;

  fifo_wr_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .eligible_i (eligible),
    .last_i     (last_q),
    .valid_o    (pick_valid),
    .grant_o    (pick_idx)
  );

  assign issue = pick_valid && (credits_q != '0);

  always_comb begin
    ack_d     = '0;
    wr_d      = 1'b0;
    data_d    = data_q;
    last_d    = last_q;
    credits_d = credits_q;
    err_d     = err_q;

    if (issue) begin
      ack_d[pick_idx] = 1'b1;
      wr_d            = 1'b1;
      last_d          = pick_idx;
      for (int i = 0; i < NREQ; i++) begin
        if (pick_idx == IW'(i)) data_d = req_data[i*DW +: DW];
      end
    end

    case ({issue, fifo_pop})
      2'b10:   credits_d = credits_q - CW'(1);
      // A pop with every slot already free cannot be real; saturate.
      2'b01:   credits_d = (credits_q == CRED_FULL) ? credits_q : credits_q + CW'(1);
      default: credits_d = credits_q;
    endcase

    if (fifo_pop && (credits_q == CRED_FULL)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q     <= '0;
      wr_q      <= 1'b0;
      data_q    <= '0;
      last_q    <= IW'(NREQ - 1);
      credits_q <= CRED_FULL;
      err_q     <= 1'b0;
    end else begin
      ack_q     <= ack_d;
      wr_q      <= wr_d;
      data_q    <= data_d;
      last_q    <= last_d;
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  assign ack          = ack_q;
  assign fifo_wr      = wr_q;
  assign fifo_data_in = data_q;
  assign credits      = credits_q;
  assign err_pop      = err_q;

endmodule
